store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 27 ++
 rtl/store_buffer_match.sv | 39 +++
 rtl/store_buffer.sv | 167 ++++++++++++++++
 tb/tb_store_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared pipeline definitions for the store buffer: the entry record,
// the drain state enum and the RISC-V funct3 size codes.
// The entry field widths are the pipeline's data-memory widths; the
// store_buffer parameters DM_ADDRESS and DATA_W are expected to match them.
package store_buffer_pkg;

    localparam int SB_ADDR_W = 9;
    localparam int SB_DATA_W = 32;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_LW = 3'b010;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [2:0]           funct3;
        logic                 valid;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// sb_match: combinational youngest-first search of the buffer slots for a
// word-address match. Slots are scanned from oldest (tail) to youngest
// (tail-1) so the last hit found wins and reports the youngest entry.
module sb_match #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 7
) (
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH*WORD_W-1:0] words,
    input  logic [$clog2(DEPTH)-1:0] tail,
    input  logic [WORD_W-1:0]       ld_word,
    output logic                    hit,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match[gi] = valid[gi] && (words[gi*WORD_W +: WORD_W] == ld_word);
    end

    // Age-ordered priority pick: the youngest matching slot overrides older ones.
    always_comb begin
        logic [PTR_W-1:0] slot;
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            slot = tail - PTR_W'(k);
            if (match[slot]) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of committed stores that drains to data
// memory through a req/ack handshake and screens loads against pending
// stores. Optional macro SB_FWD_EN enables forwarding of a full-word store
// to a full-word load; without it every conflicting load stalls.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [DM_ADDRESS-1:0]      st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [2:0]                 st_funct3,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [DM_ADDRESS-1:0]      ld_addr,
    input  logic [2:0]                 ld_funct3,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_stall,
    output logic                       mem_req,
    output logic [DM_ADDRESS-1:0]      mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [2:0]                 mem_funct3,
    input  logic                       mem_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = DM_ADDRESS - 2;

    sb_entry_t        entry_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    sb_state_t        state_reg;
    logic             mem_req_reg;

    logic push;
    logic pop;

    // A full buffer refuses a store even when the head drains this cycle.
    assign st_ready   = (count_reg < CNT_W'(DEPTH));
    assign push       = st_valid && st_ready;
    assign pop        = mem_ack && (state_reg == SB_DRAIN);
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    assign empty = (count_reg == '0);
    assign count = count_reg;

    // Each slot is written by a push at the tail and invalidated by a pop at the head.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset) begin
                entry_reg[gi] <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
                entry_reg[gi] <= '{addr:   SB_ADDR_W'(st_addr),
                                   data:   SB_DATA_W'(st_data),
                                   funct3: st_funct3,
                                   valid:  1'b1};
            end else if (pop && (head_reg == PTR_W'(gi))) begin
                entry_reg[gi].valid <= 1'b0;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Drain FSM looks at next occupancy so a fresh push requests memory one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= SB_IDLE;
            mem_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                SB_IDLE: begin
                    if (count_next != '0) begin
                        state_reg   <= SB_DRAIN;
                        mem_req_reg <= 1'b1;
                    end
                end
                SB_DRAIN: begin
                    if (count_next == '0) begin
                        state_reg   <= SB_IDLE;
                        mem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= SB_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // The head slot cannot change until it is acknowledged, keeping mem_* stable.
    assign mem_req    = mem_req_reg;
    assign mem_addr   = DM_ADDRESS'(entry_reg[head_reg].addr);
    assign mem_wdata  = DATA_W'(entry_reg[head_reg].data);
    assign mem_funct3 = entry_reg[head_reg].funct3;

    logic [DEPTH-1:0]        slot_valid;
    logic [DEPTH*WORD_W-1:0] slot_words;
    logic                    match_hit;
    logic [PTR_W-1:0]        match_idx;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_words
        assign slot_valid[gi]                   = entry_reg[gi].valid;
        assign slot_words[gi*WORD_W +: WORD_W]  = WORD_W'(DM_ADDRESS'(entry_reg[gi].addr) >> 2);
    end

    sb_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_match (
        .valid   (slot_valid),
        .words   (slot_words),
        .tail    (tail_reg),
        .ld_word (WORD_W'(ld_addr >> 2)),
        .hit     (match_hit),
        .idx     (match_idx)
    );

`ifdef SB_FWD_EN
    // Only a youngest full-word store can satisfy a full-word load; anything else waits.
    always_comb begin
        ld_hit   = 1'b0;
        ld_stall = 1'b0;
        ld_data  = '0;
        if (ld_valid && match_hit) begin
            if ((entry_reg[match_idx].funct3 == F3_SW) && (ld_funct3 == F3_LW)) begin
                ld_hit  = 1'b1;
                ld_data = DATA_W'(entry_reg[match_idx].data);
            end else begin
                ld_stall = 1'b1;
            end
        end
    end
`else
    // Without forwarding any conflicting load simply waits for the drain.
    assign ld_hit   = 1'b0;
    assign ld_data  = '0;
    assign ld_stall = ld_valid && match_hit;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ld_funct3, match_idx};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based model of the buffer.
// Honours SB_FWD_EN in the same way as the design.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic          clk;
    logic          reset;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [2:0]    st_funct3;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [2:0]    ld_funct3;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_funct3;
    logic          mem_ack;
    logic          empty;
    logic [$clog2(DEPTH):0] count;

    store_buffer #(.DEPTH(DEPTH), .DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_funct3  (st_funct3),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_funct3  (ld_funct3),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_stall   (ld_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_ack    (mem_ack),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending stores in program order, oldest at index 0.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    f;
    } st_t;

    st_t mq[$];
    int  n_drained = 0;

    task automatic check_outputs();
        logic          exp_hit;
        logic          exp_stall;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] qa;
        int            found;
        check_eq("count",    64'(count),    64'(mq.size()));
        check_eq("st_ready", 64'(st_ready), 64'(mq.size() < DEPTH));
        check_eq("empty",    64'(empty),    64'(mq.size() == 0));
        check_eq("mem_req",  64'(mem_req),  64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_eq("mem_addr",   64'(mem_addr),   64'(mq[0].a));
            check_eq("mem_wdata",  64'(mem_wdata),  64'(mq[0].d));
            check_eq("mem_funct3", 64'(mem_funct3), 64'(mq[0].f));
        end
        exp_hit   = 1'b0;
        exp_stall = 1'b0;
        exp_data  = '0;
        found     = -1;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            qa = mq[i].a;
            if (found < 0 && qa[AW-1:2] == ld_addr[AW-1:2]) found = i;
        end
        if (ld_valid && found >= 0) begin
`ifdef SB_FWD_EN
            if (mq[found].f == 3'b010 && ld_funct3 == 3'b010) begin
                exp_hit  = 1'b1;
                exp_data = mq[found].d;
            end else begin
                exp_stall = 1'b1;
            end
`else
            exp_stall = 1'b1;
`endif
        end
        check_eq("ld_hit",   64'(ld_hit),   64'(exp_hit));
        check_eq("ld_stall", 64'(ld_stall), 64'(exp_stall));
        check_eq("ld_data",  64'(ld_data),  64'(exp_data));
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic step(input logic rs, input logic sv, input logic [AW-1:0] sa,
                        input logic [DW-1:0] sd, input logic [2:0] sf,
                        input logic lv, input logic [AW-1:0] la, input logic [2:0] lf,
                        input logic ak);
        logic do_pop;
        logic do_push;
        reset     = rs;
        st_valid  = sv;
        st_addr   = sa;
        st_data   = sd;
        st_funct3 = sf;
        ld_valid  = lv;
        ld_addr   = la;
        ld_funct3 = lf;
        mem_ack   = ak;
        #1;
        check_outputs();
        do_pop  = ak && (mq.size() > 0);
        do_push = sv && (mq.size() < DEPTH);
        if (do_pop && !rs)
            $display("[TB] drain #%0d addr=0x%0h data=0x%0h f3=%0d", n_drained, mq[0].a, mq[0].d, mq[0].f);
        @(posedge clk);
        if (rs) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                n_drained++;
            end
            if (do_push) mq.push_back('{a: sa, d: sd, f: sf});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ak);
        step(1'b0, 1'b0, '0, '0, 3'b000, 1'b0, '0, 3'b000, ak);
    endtask

    task automatic push_sw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] f);
        step(1'b0, 1'b1, a, d, f, 1'b0, '0, 3'b000, 1'b0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) idle(1'b1);
        check_eq("drain_bound", 64'(empty), 64'(1));
    endtask

    logic [2:0] ld_f3_tbl [5];
    logic [2:0] sf;
    logic [2:0] lf;
    int         off;

    initial begin
        ld_f3_tbl[0] = 3'b000; ld_f3_tbl[1] = 3'b001; ld_f3_tbl[2] = 3'b010;
        ld_f3_tbl[3] = 3'b100; ld_f3_tbl[4] = 3'b101;

        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with a load presented and a stray ack while idle.
        step(1'b0, 1'b0, '0, '0, 3'b000, 1'b1, 9'h100, 3'b010, 1'b1);
        check_eq("rst_count", 64'(count), 64'(0));

        // Single SW held unacknowledged for five cycles, then drained.
        push_sw(9'h100, 32'hDEADBEEF, 3'b010);
        repeat (5) idle(1'b0);
        check_eq("s1_addr", 64'(mem_addr), 64'(9'h100));
        idle(1'b1);
        check_eq("s1_empty", 64'(empty), 64'(1));

        // Fill to full; the fifth store meets an ack and is still refused.
        for (int i = 0; i < DEPTH; i++) push_sw(9'(9'h180 + 4 * i), 32'(i + 10), 3'b010);
        check_eq("s2_ready", 64'(st_ready), 64'(0));
        step(1'b0, 1'b1, 9'h1F0, 32'h55, 3'b010, 1'b0, '0, 3'b000, 1'b1);
        check_eq("s2_count", 64'(count), 64'(3));
        drain_all();

        // Two SWs to one word; the load sees the younger one (or stalls).
        push_sw(9'h104, 32'd1, 3'b010);
        push_sw(9'h104, 32'd2, 3'b010);
        step(1'b0, 1'b0, '0, '0, 3'b000, 1'b1, 9'h104, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 3'b000, 1'b1, 9'h104, 3'b010, 1'b1);

        // A byte store blocks a word load of the same word only.
        push_sw(9'h105, 32'hAA, 3'b000);
        step(1'b0, 1'b0, '0, '0, 3'b000, 1'b1, 9'h104, 3'b010, 1'b0);
        step(1'b0, 1'b0, '0, '0, 3'b000, 1'b1, 9'h108, 3'b010, 1'b0);
        drain_all();

        // Reset in the middle of a drain discards everything.
        for (int i = 0; i < 3; i++) push_sw(9'(9'h140 + 4 * i), 32'(i + 100), 3'b010);
        step(1'b1, 1'b0, '0, '0, 3'b000, 1'b0, '0, 3'b000, 1'b0);
        check_eq("s5_mem_req", 64'(mem_req), 64'(0));
        check_eq("s5_count",   64'(count),   64'(0));
        repeat (3) idle(1'b1);

        // Back-to-back push and ack for twenty stores (head wraps repeatedly).
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 9'(9'h100 + 4 * (i % 8)), 32'(i), 3'b010, 1'b0, '0, 3'b000, 1'b1);
        drain_all();

        // Randomized traffic; stores are only offered when the model has room.
        for (int c = 0; c < 500; c++) begin
            sf  = 3'($urandom_range(0, 2));
            off = (sf == 3'b000) ? int'($urandom_range(0, 3)) : (sf == 3'b001) ? 2 * int'($urandom_range(0, 1)) : 0;
            lf  = ld_f3_tbl[$urandom_range(0, 4)];
            step(1'b0,
                 (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1),
                 9'(9'h100 + 4 * $urandom_range(0, 7) + off),
                 $urandom, sf,
                 ($urandom_range(0, 3) != 0),
                 9'(9'h100 + 4 * $urandom_range(0, 7)),
                 lf,
                 ($urandom_range(0, 2) != 0));
        end
        drain_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
